// File: rtl/vga_line_fetch_if.sv
// Memory read port of the line fetcher.
//   mem_req  : read request, held until mem_ack
//   mem_addr : word address, stable while mem_req=1
//   mem_ack  : one-cycle acknowledge, mem_data valid in the same cycle
//   mem_data : WORD_PIX packed {R,G,B} pixels, pixel p at bits [3p+2:3p]
// master = line fetcher, slave = memory.
interface vga_line_fetch_if #(
  parameter int ADDR_W   = 16,
  parameter int WORD_PIX = 8
);
  logic                    mem_req;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_ack;
  logic [3*WORD_PIX-1:0]   mem_data;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/vga_line_fetch.sv
// Double-buffered scanline fetcher for the VGA output stage.
// The back half of the line buffer is filled from word-wide memory while the
// front half is serialised one 3-bit {R,G,B} pixel per pix_en cycle.
// Ports:
//   clk        : clock, all logic on rising edge
//   rst_n      : synchronous active-low reset
//   line_start : 1-cycle pulse, swaps buffers and starts fetching fetch_line
//   fetch_line : line number to fetch, sampled on line_start
//   pix_en     : active-video strobe, one pixel per cycle
//   mem        : memory read port (master side)
//   rgb        : registered pixel output, 0 when blanking
//   fetch_busy : fetch in progress
//   underrun   : sticky, a fetch was aborted by line_start before completing
module vga_line_fetch #(
  parameter int H_ACTIVE = 640,
  parameter int WORD_PIX = 8,
  parameter int ADDR_W   = 16,
  parameter int BASE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [8:0]            fetch_line,
  input  logic                  pix_en,
  vga_line_fetch_if.master      mem,
  output logic [2:0]            rgb,
  output logic                  fetch_busy,
  output logic                  underrun
);

  localparam int WORDS  = H_ACTIVE / WORD_PIX;
  localparam int WORD_W = 3 * WORD_PIX;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PX_W   = $clog2(H_ACTIVE + 1);
  localparam int LANE_W = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;

  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(WORDS - 1);
  localparam logic [PX_W-1:0]   PX_END    = PX_W'(H_ACTIVE);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  logic [0:0]        state_reg;
  logic [WIDX_W-1:0] widx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              underrun_reg;
  logic              front_sel_reg;
  logic [PX_W-1:0]   px_reg;
  logic [2:0]        rgb_reg;

  // Two line halves; index 0/1 selected by front_sel_reg (read) or its inverse (write).
  logic [WORD_W-1:0] line_buf [0:1][0:WORDS-1];

  logic              last_word;
  logic              wr_en;
  logic [ADDR_W-1:0] start_addr;
  logic [WIDX_W-1:0] rd_idx;
  logic [LANE_W-1:0] lane_idx;
  logic [WORD_W-1:0] rd_word;
  logic [2:0]        lane [WORD_PIX];

  assign last_word  = (widx_reg == LAST_WIDX);
  // Address wraps modulo 2^ADDR_W by truncation.
  assign start_addr = ADDR_W'(BASE + int'(fetch_line) * WORDS);

  // A non-final ack that coincides with line_start belongs to the aborted
  // fetch and is dropped; the final one still completes the line.
  assign wr_en = rst_n && (state_reg == ST_FETCH) && mem.mem_ack &&
                 (last_word || !line_start);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[~front_sel_reg][widx_reg] <= mem.mem_data;
    end
  end

  // Fetch FSM and buffer select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      widx_reg      <= '0;
      addr_reg      <= '0;
      underrun_reg  <= 1'b0;
      front_sel_reg <= 1'b0;
    end else begin
      if (line_start) begin
        front_sel_reg <= ~front_sel_reg;
      end
      case (state_reg)
        ST_IDLE: begin
          if (line_start) begin
            state_reg <= ST_FETCH;
            widx_reg  <= '0;
            addr_reg  <= start_addr;
          end
        end
        ST_FETCH: begin
          if (line_start) begin
            if (!(mem.mem_ack && last_word)) begin
              underrun_reg <= 1'b1;
            end
            widx_reg <= '0;
            addr_reg <= start_addr;
          end else if (mem.mem_ack) begin
            if (last_word) begin
              state_reg <= ST_IDLE;
            end else begin
              widx_reg <= widx_reg + 1'b1;
              addr_reg <= addr_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Pixel path: word of the front half at px, then lane select into rgb_reg.
  assign rd_idx   = WIDX_W'(px_reg / WORD_PIX);
  assign lane_idx = LANE_W'(px_reg % WORD_PIX);
  assign rd_word  = line_buf[front_sel_reg][rd_idx];

  generate
    for (genvar gi = 0; gi < WORD_PIX; gi++) begin : g_lane
      assign lane[gi] = rd_word[3*gi +: 3];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_reg  <= '0;
      rgb_reg <= '0;
    end else if (line_start) begin
      px_reg  <= '0;
      rgb_reg <= '0;
    end else if (pix_en && (px_reg < PX_END)) begin
      px_reg  <= px_reg + 1'b1;
      rgb_reg <= lane[lane_idx];
    end else begin
      rgb_reg <= '0;
    end
  end

  assign mem.mem_req  = (state_reg == ST_FETCH);
  assign mem.mem_addr = addr_reg;
  assign fetch_busy   = (state_reg == ST_FETCH);
  assign underrun     = underrun_reg;
  assign rgb          = rgb_reg;

endmodule

// File: tb/tb_vga_line_fetch.sv
module tb_vga_line_fetch;

  logic       clk;
  logic       rst_n;
  logic       line_start;
  logic [8:0] fetch_line;
  logic       pix_en;
  logic [2:0] rgb;
  logic       fetch_busy;
  logic       underrun;

  vga_line_fetch_if #(.ADDR_W(16), .WORD_PIX(8)) mem_if ();

  vga_line_fetch #(.H_ACTIVE(640), .WORD_PIX(8), .ADDR_W(16), .BASE(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .fetch_line (fetch_line),
    .pix_en     (pix_en),
    .mem        (mem_if.master),
    .rgb        (rgb),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder state
  bit auto_resp = 0;
  bit man_ack   = 0;
  int acks_left = 0;   // -1 = unlimited
  int wait_cnt  = 0;
  int ack_count = 0;
  int exp_addr  = 0;

  typedef struct {
    bit ls;
    int fl;
    bit ack;
    bit exp_req;
    int exp_addr;
    bit exp_busy;
  } vec_t;

  vec_t vecs [8];

  // Memory contents: pixel p of the word at address a.
  function automatic logic [2:0] pix_of(input int a, input int p);
    return 3'(a * 5 + p * 3 + (a >> 3));
  endfunction

  function automatic logic [23:0] mem_word(input int a);
    logic [23:0] w;
    w = '0;
    for (int p = 0; p < 8; p++) w[3*p +: 3] = pix_of(a, p);
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive inputs (and the memory response), step, land #1 after the edge.
  task automatic cycle(input bit ls, input int fl, input bit pe);
    bit ack;
    ack = 1'b0;
    if (auto_resp) begin
      if (mem_if.mem_req && acks_left != 0) begin
        if (wait_cnt == 0) begin
          ack = 1'b1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      ack = man_ack;
    end
    mem_if.mem_ack  = ack;
    mem_if.mem_data = ack ? mem_word(int'(mem_if.mem_addr)) : 24'd0;
    if (ack && mem_if.mem_req) begin
      chk("ack_addr", int'(mem_if.mem_addr), exp_addr);
      exp_addr++;
      ack_count++;
      if (acks_left > 0) acks_left--;
    end
    if (ls) begin
      exp_addr  = 80 * fl;
      ack_count = 0;
    end
    line_start = ls;
    fetch_line = 9'(fl);
    pix_en     = pe;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    pix_en     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (fetch_busy && guard < 1000) begin
      cycle(0, 0, 0);
      guard++;
    end
    chk(name, int'(fetch_busy), 0);
  endtask

  task automatic wait_acks(input int n);
    int guard;
    guard = 0;
    while (ack_count < n && guard < 1000) begin
      cycle(0, 0, 0);
      guard++;
    end
    chk("acks_reached", ack_count, n);
  endtask

  // Stream one line from the front buffer and compare every pixel.
  task automatic stream_line(input int ln, input bit gaps);
    int px;
    int guard;
    bit pe;
    px = 0;
    guard = 0;
    while (px < 640 && guard < 3000) begin
      pe = gaps ? ($urandom_range(0, 7) != 0) : 1'b1;
      cycle(0, 0, pe);
      if (pe) begin
        chk($sformatf("rgb_l%0d_px%0d", ln, px), int'(rgb),
            int'(pix_of(80 * ln + px / 8, px % 8)));
        px++;
      end else begin
        chk($sformatf("rgb_blank_l%0d_px%0d", ln, px), int'(rgb), 0);
      end
      guard++;
    end
    chk("stream_done", px, 640);
    cycle(0, 0, 1);
    chk("rgb_past_end", int'(rgb), 0);
    cycle(0, 0, 0);
    chk("rgb_no_pix_en", int'(rgb), 0);
  endtask

  initial begin
    vecs[0] = '{ls:0, fl:0, ack:0, exp_req:0, exp_addr:0,   exp_busy:0};
    vecs[1] = '{ls:0, fl:0, ack:1, exp_req:0, exp_addr:0,   exp_busy:0};
    vecs[2] = '{ls:1, fl:3, ack:0, exp_req:1, exp_addr:240, exp_busy:1};
    vecs[3] = '{ls:0, fl:0, ack:0, exp_req:1, exp_addr:240, exp_busy:1};
    vecs[4] = '{ls:0, fl:0, ack:1, exp_req:1, exp_addr:241, exp_busy:1};
    vecs[5] = '{ls:0, fl:0, ack:1, exp_req:1, exp_addr:242, exp_busy:1};
    vecs[6] = '{ls:0, fl:0, ack:0, exp_req:1, exp_addr:242, exp_busy:1};
    vecs[7] = '{ls:0, fl:0, ack:1, exp_req:1, exp_addr:243, exp_busy:1};

    rst_n = 1'b0;
    line_start = 1'b0;
    fetch_line = '0;
    pix_en = 1'b0;
    mem_if.mem_ack = 1'b0;
    mem_if.mem_data = '0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("rst_req",  int'(mem_if.mem_req), 0);
    chk("rst_addr", int'(mem_if.mem_addr), 0);
    chk("rst_busy", int'(fetch_busy), 0);
    chk("rst_rgb",  int'(rgb), 0);
    chk("rst_und",  int'(underrun), 0);
    rst_n = 1'b1;

    // Test 1 and start of test 2: table-driven, manual acks
    for (int i = 0; i < 8; i++) begin
      man_ack = vecs[i].ack;
      cycle(vecs[i].ls, vecs[i].fl, 0);
      chk($sformatf("vec%0d_req", i),  int'(mem_if.mem_req),  int'(vecs[i].exp_req));
      chk($sformatf("vec%0d_addr", i), int'(mem_if.mem_addr), vecs[i].exp_addr);
      chk($sformatf("vec%0d_busy", i), int'(fetch_busy),      int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_rgb", i),  int'(rgb),             0);
      chk($sformatf("vec%0d_und", i),  int'(underrun),        0);
    end
    man_ack = 1'b0;

    // Test 2: rest of line 3 with random waits
    auto_resp = 1;
    acks_left = -1;
    wait_cnt = 0;
    wait_idle("t2_idle");
    chk("t2_acks", ack_count, 80);
    chk("t2_req_low", int'(mem_if.mem_req), 0);
    chk("t2_und", int'(underrun), 0);

    // Test 3: stream line 3 with pix_en gaps while line 4 fetches
    cycle(1, 4, 0);
    chk("t3_ls_rgb", int'(rgb), 0);
    chk("t3_addr", int'(mem_if.mem_addr), 320);
    stream_line(3, 1);
    wait_idle("t3_idle");
    chk("t3_acks", ack_count, 80);

    // Test 4: underrun after 40 words
    cycle(1, 5, 0);
    acks_left = 40;
    wait_acks(40);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("t4_busy", int'(fetch_busy), 1);
    chk("t4_und_before", int'(underrun), 0);
    cycle(1, 6, 0);
    chk("t4_und", int'(underrun), 1);
    chk("t4_req", int'(mem_if.mem_req), 1);
    chk("t4_addr", int'(mem_if.mem_addr), 480);
    acks_left = -1;
    wait_idle("t4_idle");
    chk("t4_acks", ack_count, 80);
    cycle(1, 7, 0);
    stream_line(6, 0);
    chk("t4_und_sticky", int'(underrun), 1);
    wait_idle("t4_idle7");

    // Test 6: reset in the middle of a fetch
    cycle(1, 8, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    chk("t6_req_before", int'(mem_if.mem_req), 1);
    auto_resp = 0;
    rst_n = 1'b0;
    cycle(0, 0, 0);
    chk("t6_req",  int'(mem_if.mem_req), 0);
    chk("t6_addr", int'(mem_if.mem_addr), 0);
    chk("t6_busy", int'(fetch_busy), 0);
    chk("t6_rgb",  int'(rgb), 0);
    chk("t6_und",  int'(underrun), 0);
    rst_n = 1'b1;
    auto_resp = 1;
    wait_cnt = 0;

    // Test 5: final ack coincident with line_start (pix_en also high)
    cycle(1, 9, 0);
    chk("t5_addr0", int'(mem_if.mem_addr), 720);
    acks_left = 79;
    wait_acks(79);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    chk("t5_busy", int'(fetch_busy), 1);
    chk("t5_addr_last", int'(mem_if.mem_addr), 799);
    auto_resp = 0;
    man_ack = 1'b1;
    cycle(1, 10, 1);
    man_ack = 1'b0;
    chk("t5_und", int'(underrun), 0);
    chk("t5_req", int'(mem_if.mem_req), 1);
    chk("t5_addr", int'(mem_if.mem_addr), 800);
    chk("t5_rgb", int'(rgb), 0);
    auto_resp = 1;
    acks_left = -1;
    wait_cnt = 0;
    stream_line(9, 0);
    wait_idle("t5_idle");
    chk("t5_acks", ack_count, 80);
    chk("t5_und_end", int'(underrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
